// File: rtl/int_ctrl18.sv
// int_ctrl18: interrupt controller in front of Core18.
// Synchronises and edge-detects 15 request lines, latches them as pending,
// masks them and presents the highest eligible vector to the core until the
// core is seen dispatching to it. Mask and pending are visible on the port bus.
module int_ctrl18 #(
    parameter logic [17:0] PORT_BASE = 18'o000040
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RUN,
    input  logic [14:0] IRQ,
    input  logic [11:0] PC,
    input  logic        PORT_WR,
    input  logic        PORT_RD,
    input  logic [17:0] ADRS,
    input  logic [17:0] DATAOUT,
    output logic [3:0]  VECTOR,
    output logic [17:0] PORT_DATA,
    output logic        INT_ACK
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, GAP = 2'd2} state_t;

    state_t      state, state_n;
    logic [14:0] s1, s2, s3;
    logic [2:0]  arm;
    logic [14:0] rise;
    logic [14:0] pending, pending_n, mask, eligible;
    logic [14:0] sw_set, sw_clr, disp_clr, cur_bit;
    logic [3:0]  cur, cur_n, vec_n;
    logic        ack_n;
    logic        hit0, hit1, hit2;
    logic        unused_ok;

    // Highest set request wins: vector 15 over vector 1.
    function automatic logic [3:0] prio_enc(input logic [14:0] req);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (req[i]) v = 4'(i + 1);
        end
        return v;
    endfunction

    // Vector number to pending-bit mask; vector 0 maps to no bit.
    function automatic logic [14:0] vec_bit(input logic [3:0] v);
        logic [15:0] t;
        t = 16'd1 << v;
        return t[15:1];
    endfunction

    assign hit0 = (ADRS == PORT_BASE);
    assign hit1 = (ADRS == PORT_BASE + 18'd1);
    assign hit2 = (ADRS == PORT_BASE + 18'd2);

    assign sw_set = (PORT_WR && hit2) ? DATAOUT[14:0] : 15'd0;
    assign sw_clr = (PORT_WR && hit1) ? DATAOUT[14:0] : 15'd0;

    assign unused_ok = &{1'b0, DATAOUT[17:15]};

    // Two-flop synchroniser plus edge-detect flop. The arm shift register
    // suppresses edges until s3 holds a post-reset sample, so a line that is
    // already high when reset is released does not count as a new event.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1  <= 15'd0;
            s2  <= 15'd0;
            s3  <= 15'd0;
            arm <= 3'd0;
        end else begin
            s1  <= IRQ;
            s2  <= s1;
            s3  <= s2;
            arm <= {arm[1:0], 1'b1};
        end
    end

    assign rise = arm[2] ? (s2 & ~s3) : 15'd0;

    // Sets win over clears on the same bit so no request is ever dropped.
    assign pending_n = (pending & ~(sw_clr | disp_clr)) | rise | sw_set;
    assign eligible  = pending & mask;
    assign cur_bit   = vec_bit(cur);

    // Software-visible mask and pending registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending <= 15'd0;
            mask    <= 15'd0;
        end else begin
            pending <= pending_n;
            if (PORT_WR && hit0) mask <= DATAOUT[14:0];
        end
    end

    // Next-state logic; with RUN low every state holds and VECTOR goes to 0.
    always_comb begin
        state_n  = state;
        cur_n    = cur;
        vec_n    = 4'd0;
        ack_n    = 1'b0;
        disp_clr = 15'd0;
        if (RUN) begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state_n = PRESENT;
                        cur_n   = prio_enc(eligible);
                        vec_n   = cur_n;
                    end
                end
                PRESENT: begin
                    if (PC == {8'b0, cur}) begin
                        disp_clr = cur_bit;
                        ack_n    = 1'b1;
                        state_n  = GAP;
                    end else if (!(|(pending & cur_bit)) || !(|(mask & cur_bit))) begin
                        state_n = GAP;
                    end else begin
                        vec_n = cur;
                    end
                end
                GAP:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // State, latched vector and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            cur     <= 4'd0;
            VECTOR  <= 4'd0;
            INT_ACK <= 1'b0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            VECTOR  <= vec_n;
            INT_ACK <= ack_n;
        end
    end

    // Port read mux; drives 0 whenever no register is being read.
    always_comb begin
        PORT_DATA = 18'd0;
        if (PORT_RD) begin
            if (hit0)      PORT_DATA = {3'b0, mask};
            else if (hit1) PORT_DATA = {3'b0, pending};
            else if (hit2) PORT_DATA = {14'b0, VECTOR};
        end
    end

endmodule

// File: tb/tb_int_ctrl18.sv
// Scoreboard bench for int_ctrl18: stimulus pushes expected VECTOR/INT_ACK
// events and expected read data; a monitor compares them as the DUT shows them.
module tb_int_ctrl18;

    localparam logic [17:0] BASE = 18'o000040;

    logic        CLK;
    logic        RESET_N;
    logic        RUN;
    logic [14:0] IRQ;
    logic [11:0] PC;
    logic        PORT_WR;
    logic        PORT_RD;
    logic [17:0] ADRS;
    logic [17:0] DATAOUT;
    logic [3:0]  VECTOR;
    logic [17:0] PORT_DATA;
    logic        INT_ACK;

    int          cyc = 0;
    bit          done = 0;

    int          ev_vec[$];
    int          ev_ack[$];
    int          ev_at[$];
    string       ev_name[$];
    logic [17:0] rd_exp[$];
    string       rd_name[$];

    int_ctrl18 #(.PORT_BASE(BASE)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .IRQ(IRQ), .PC(PC),
        .PORT_WR(PORT_WR), .PORT_RD(PORT_RD), .ADRS(ADRS), .DATAOUT(DATAOUT),
        .VECTOR(VECTOR), .PORT_DATA(PORT_DATA), .INT_ACK(INT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge count; read between edges it equals the number of edges so far.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic exp_ev(input int vec, input int ack, input int at, input string name);
        ev_vec.push_back(vec);
        ev_ack.push_back(ack);
        ev_at.push_back(at);
        ev_name.push_back(name);
    endtask

    task automatic wr(input int off, input logic [14:0] d);
        PORT_WR = 1'b1;
        ADRS    = BASE + 18'(off);
        DATAOUT = {3'b0, d};
        tick();
        PORT_WR = 1'b0;
        ADRS    = 18'd0;
        DATAOUT = 18'd0;
    endtask

    task automatic rd(input int off, input logic [17:0] expv, input string name);
        rd_exp.push_back(expv);
        rd_name.push_back(name);
        PORT_RD = 1'b1;
        ADRS    = BASE + 18'(off);
        tick();
        PORT_RD = 1'b0;
        ADRS    = 18'd0;
    endtask

    // Monitor: an event is any VECTOR change or any cycle with INT_ACK high.
    initial begin
        int          total = 0;
        int          bad = 0;
        logic [3:0]  prev_vec = 4'd0;
        int          e_vec, e_ack, e_at;
        string       e_name;
        logic [17:0] r_exp;
        string       r_name;
        forever begin
            @(negedge CLK);
            if (done) begin
                total++;
                if (ev_vec.size() != 0) begin
                    bad++;
                    $display("FAIL events_drained: %0d expected events never seen, required 0 (next %s)",
                             ev_vec.size(), ev_name[0]);
                end
                total++;
                if (rd_exp.size() != 0) begin
                    bad++;
                    $display("FAIL reads_drained: %0d expected reads never seen, required 0", rd_exp.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (VECTOR !== prev_vec || INT_ACK !== 1'b0) begin
                total++;
                if (ev_vec.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got vector=%0d ack=%b at cycle %0d, required no event",
                             VECTOR, INT_ACK, cyc);
                end else begin
                    e_vec  = ev_vec.pop_front();
                    e_ack  = ev_ack.pop_front();
                    e_at   = ev_at.pop_front();
                    e_name = ev_name.pop_front();
                    if (VECTOR !== 4'(e_vec) || INT_ACK !== 1'(e_ack) || (e_at >= 0 && cyc != e_at)) begin
                        bad++;
                        $display("FAIL %s: got vector=%0d ack=%b cycle=%0d, required vector=%0d ack=%0d cycle=%0d",
                                 e_name, VECTOR, INT_ACK, cyc, e_vec, e_ack, e_at);
                    end
                end
            end
            prev_vec = VECTOR;
            if (PORT_RD === 1'b1) begin
                total++;
                if (rd_exp.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_read: got data=%h, required no read", PORT_DATA);
                end else begin
                    r_exp  = rd_exp.pop_front();
                    r_name = rd_name.pop_front();
                    if (PORT_DATA !== r_exp) begin
                        bad++;
                        $display("FAIL %s: got data=%h, required %h", r_name, PORT_DATA, r_exp);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        int t;
        RESET_N = 1'b1;
        RUN     = 1'b0;
        IRQ     = 15'h7FFF;
        PC      = 12'd0;
        PORT_WR = 1'b0;
        PORT_RD = 1'b0;
        ADRS    = 18'd0;
        DATAOUT = 18'd0;
        #1 RESET_N = 1'b0;

        // Reset with all lines high: everything reads 0, no pending after release.
        tick(3);
        rd(0, 18'd0, "rst_mask");
        rd(1, 18'd0, "rst_pend");
        rd(2, 18'd0, "rst_vec");
        RESET_N = 1'b1;
        tick(6);
        rd(1, 18'd0, "pend_after_release");
        IRQ = 15'd0;
        RUN = 1'b1;
        tick(4);
        wr(0, 15'h7FFF);
        tick(2);

        // Basic dispatch of vector 5.
        t = cyc; IRQ = 15'h0010;
        exp_ev(5, 0, t + 4, "vec5_latency");
        tick(3); IRQ = 15'd0; tick(3);
        rd(1, 18'h00010, "pend5_set");
        t = cyc; PC = 12'o0005;
        exp_ev(0, 1, t + 1, "ack5");
        tick(); PC = 12'd0; tick(2);
        rd(1, 18'd0, "pend5_cleared");

        // Priority and hold: 3 stays presented while 9 and 12 arrive.
        t = cyc; IRQ = 15'h0004;
        exp_ev(3, 0, t + 4, "vec3");
        tick(5); IRQ = 15'h0904; tick(6); IRQ = 15'd0; tick(3);
        rd(1, 18'h00904, "pend_3_9_12");
        t = cyc; PC = 12'd3;
        exp_ev(0, 1, t + 1, "ack3");
        exp_ev(12, 0, t + 3, "vec12_after_gap");
        tick(); PC = 12'd0; tick(4);
        t = cyc; PC = 12'd12;
        exp_ev(0, 1, t + 1, "ack12");
        exp_ev(9, 0, t + 3, "vec9_after_gap");
        tick(); PC = 12'd0; tick(4);
        t = cyc; PC = 12'd9;
        exp_ev(0, 1, t + 1, "ack9");
        tick(); PC = 12'd0; tick(3);
        rd(1, 18'd0, "pend_empty");

        // Mask withdraw and re-present of vector 7.
        t = cyc; IRQ = 15'h0040;
        exp_ev(7, 0, t + 4, "vec7");
        tick(3); IRQ = 15'd0; tick(3);
        t = cyc;
        exp_ev(0, 0, t + 2, "withdraw7_no_ack");
        wr(0, 15'd0);
        tick(2);
        rd(1, 18'h00040, "pend7_kept");
        rd(0, 18'd0, "mask_zero");
        t = cyc;
        exp_ev(7, 0, t + 2, "vec7_again");
        wr(0, 15'h0040);
        tick(2);
        rd(2, 18'd7, "rd_vector7");
        t = cyc; PC = 12'd7;
        exp_ev(0, 1, t + 1, "ack7");
        tick(); PC = 12'd0; tick(2);
        wr(0, 15'h7FFF);
        tick(2);

        // Software set, then a clear colliding with a fresh IRQ[0] rise.
        t = cyc;
        exp_ev(1, 0, t + 2, "vec1_swset");
        wr(2, 15'h0001);
        tick(2);
        IRQ = 15'h0001;
        tick(2);
        wr(1, 15'h0001);
        tick(3); IRQ = 15'd0; tick(3);
        rd(1, 18'h00001, "set_wins_over_clear");
        t = cyc;
        exp_ev(0, 0, t + 2, "w1c_withdraw");
        wr(1, 15'h0001);
        tick(2);
        rd(1, 18'd0, "w1c_cleared");

        // RUN gating while vector 5 is presented.
        t = cyc; IRQ = 15'h0010;
        exp_ev(5, 0, t + 4, "vec5_again");
        tick(3); IRQ = 15'd0; tick(3);
        t = cyc; RUN = 1'b0;
        exp_ev(0, 0, t + 1, "run_off_vec0");
        tick(2); PC = 12'd5; tick(3); PC = 12'd0; tick();
        rd(1, 18'h00010, "pend5_run_off");
        rd(2, 18'd0, "rd_vector_run_off");
        t = cyc; RUN = 1'b1;
        exp_ev(5, 0, t + 1, "run_on_vec5");
        tick(3);
        t = cyc; PC = 12'd5;
        exp_ev(0, 1, t + 1, "ack5_after_run");
        tick(); PC = 12'd0; tick(3);

        // Reset while vector 10 is presented: drops at once, state lost.
        t = cyc; IRQ = 15'h0200;
        exp_ev(10, 0, t + 4, "vec10");
        tick(3); IRQ = 15'd0; tick(3);
        #2;
        exp_ev(0, 0, -1, "reset_drop");
        RESET_N = 1'b0;
        tick();
        rd(1, 18'd0, "pend_lost_in_reset");
        rd(0, 18'd0, "mask_lost_in_reset");
        RESET_N = 1'b1;
        tick(5);
        rd(1, 18'd0, "pend_after_reset2");
        tick(2);
        done = 1;
    end

endmodule
